fixed_learning_neuron: RTL and testbench

FIXED_LEARNING_NEURON -- requirements
Module: fixed_learning_neuron

---
 rtl/fixed_learning_neuron_pkg.sv | 34 +++
 rtl/fixed_learning_neuron_sat_mac.sv | 24 ++
 rtl/fixed_learning_neuron.sv | 180 ++++++++++++++++++
 tb/tb_fixed_learning_neuron.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_learning_neuron_pkg.sv
// Shared types and arithmetic helpers for the learning neuron and its MAC datapath.
package nl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MAC    = 2'd1,
    OUT    = 2'd2,
    UPDATE = 2'd3
  } state_t;

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic int one_val(input int frac_w);
    return 1 << frac_w;
  endfunction

  // Add two values and clip the sum to the signed range of a w-bit word.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] sum;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi)
      return hi;
    else if (sum < lo)
      return lo;
    else
      return sum;
  endfunction

endpackage

// File: rtl/fixed_learning_neuron_sat_mac.sv
// One signed multiply with fraction realignment, plus a saturating accumulate of
// the (learning-rate scaled) product onto a word-sized addend.
module sat_mac
  import nl_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int LR_SHIFT = 0
) (
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  input  logic signed [DATA_W-1:0]   addend,
  output logic signed [2*DATA_W-1:0] prod,
  output logic signed [DATA_W-1:0]   sum
);

  logic signed [2*DATA_W-1:0] full;

  assign full = (2*DATA_W)'(a) * (2*DATA_W)'(b);
  assign prod = full >>> FRAC_W;
  // The product is at most 2*DATA_W bits, so the 64-bit helper never overflows.
  assign sum  = DATA_W'(sat_add(64'(prod >>> LR_SHIFT), 64'(addend), DATA_W));

endmodule

// File: rtl/fixed_learning_neuron.sv
// Single perceptron-style neuron: serial MAC inference, thresholded output and an
// optional serial delta-rule weight/bias update sharing the same multiplier.
module fixed_learning_neuron
  import nl_pkg::*;
#(
  parameter int N_INPUTS = 32,
  parameter int DATA_W   = 16,
  parameter int FRAC_W   = 8,
  parameter int LR_SHIFT = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N_INPUTS*DATA_W-1:0]   in_data,
  input  logic [N_INPUTS-1:0]          in_enable,
  input  logic [DATA_W-1:0]            in_target,
  input  logic                         in_learn,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_value,
  output logic [DATA_W-1:0]            out_err,
  output logic                         busy,
  output logic [1:0]                   dbg_state,
  output logic [DATA_W-1:0]            dbg_bias,
  output logic [N_INPUTS*DATA_W-1:0]   dbg_weights
);

  localparam int ACC_W = 2*DATA_W + $clog2(N_INPUTS + 1);
  localparam int IDX_W = $clog2(N_INPUTS + 1);
  localparam int SEL_W = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_INPUTS - 1);
  localparam logic [IDX_W-1:0] BIAS_IDX = IDX_W'(N_INPUTS);
  localparam logic signed [DATA_W-1:0] ONE = DATA_W'(one_val(FRAC_W));

  // Valid/ready: a transfer happens on a rising edge where both valid and ready
  // are high; the producer holds its payload stable until that edge.

  state_t                      state;
  logic [IDX_W-1:0]            idx;
  logic [SEL_W-1:0]            sel;
  logic signed [DATA_W-1:0]    x_q [N_INPUTS];
  logic signed [DATA_W-1:0]    w_q [N_INPUTS];
  logic [N_INPUTS-1:0]         en_q;
  logic signed [DATA_W-1:0]    tgt_q;
  logic                        learn_q;
  logic signed [DATA_W-1:0]    bias_q;
  logic signed [ACC_W-1:0]     acc;

  logic signed [DATA_W-1:0]    x_sel;
  logic signed [DATA_W-1:0]    w_sel;
  logic signed [DATA_W-1:0]    mac_a;
  logic signed [DATA_W-1:0]    mac_b;
  logic signed [DATA_W-1:0]    mac_add;
  logic signed [2*DATA_W-1:0]  mac_prod;
  logic signed [DATA_W-1:0]    mac_sum;
  logic signed [DATA_W-1:0]    val_next;
  logic signed [DATA_W-1:0]    err_next;

  assign in_ready  = rst_n && (state == IDLE);
  assign busy      = (state != IDLE);
  assign dbg_state = state;
  assign dbg_bias  = bias_q;

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_dbg
    assign dbg_weights[g*DATA_W +: DATA_W] = w_q[g];
  end

  // idx reaches N_INPUTS only for the bias step; keep the array select in range.
  always_comb begin
    sel = '0;
    if (idx < BIAS_IDX)
      sel = SEL_W'(idx);
  end

  assign x_sel = x_q[sel];
  assign w_sel = w_q[sel];

  // MAC: x*w. UPDATE: err*x onto w, and err*ONE onto the bias in the last step.
  always_comb begin
    mac_a   = x_sel;
    mac_b   = w_sel;
    mac_add = w_sel;
    if (state == UPDATE) begin
      mac_a = $signed(out_err);
      if (idx == BIAS_IDX) begin
        mac_b   = ONE;
        mac_add = bias_q;
      end else begin
        mac_b   = x_sel;
        mac_add = w_sel;
      end
    end
  end

  sat_mac #(
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W),
    .LR_SHIFT (LR_SHIFT)
  ) u_sat_mac (
    .a      (mac_a),
    .b      (mac_b),
    .addend (mac_add),
    .prod   (mac_prod),
    .sum    (mac_sum)
  );

  always_comb begin
    val_next = '0;
    if (!acc[ACC_W-1] && (acc != '0))
      val_next = ONE;
    err_next = DATA_W'(sat_add(64'(tgt_q), -64'(val_next), DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      bias_q    <= '0;
      en_q      <= '0;
      tgt_q     <= '0;
      learn_q   <= 1'b0;
      out_valid <= 1'b0;
      out_value <= '0;
      out_err   <= '0;
      for (int i = 0; i < N_INPUTS; i++) begin
        w_q[i] <= '0;
        x_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int i = 0; i < N_INPUTS; i++)
              x_q[i] <= in_data[i*DATA_W +: DATA_W];
            en_q    <= in_enable;
            tgt_q   <= in_target;
            learn_q <= in_learn;
            acc     <= ACC_W'(bias_q);
            idx     <= '0;
            state   <= MAC;
          end
        end
        MAC: begin
          if (en_q[sel])
            acc <= acc + ACC_W'(mac_prod);
          if (idx == LAST_IDX)
            state <= OUT;
          else
            idx <= idx + 1'b1;
        end
        OUT: begin
          // First OUT cycle resolves the threshold; afterwards hold until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            out_value <= val_next;
            out_err   <= err_next;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            idx       <= '0;
            state     <= (learn_q && (out_err != '0)) ? UPDATE : IDLE;
          end
        end
        UPDATE: begin
          if (idx == BIAS_IDX) begin
            bias_q <= mac_sum;
            state  <= IDLE;
          end else begin
            if (en_q[sel])
              w_q[sel] <= mac_sum;
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_learning_neuron.sv
// Directed bench for the learning neuron with N_INPUTS=2, Q8.8 data, learning rate 1.
module tb_fixed_learning_neuron;

  localparam int N  = 2;
  localparam int DW = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N*DW-1:0] in_data;
  logic [N-1:0]  in_enable;
  logic [DW-1:0] in_target;
  logic          in_learn;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_value;
  logic [DW-1:0] out_err;
  logic          busy;
  logic [1:0]    dbg_state;
  logic [DW-1:0] dbg_bias;
  logic [N*DW-1:0] dbg_weights;

  logic [DW-1:0] w0;
  logic [DW-1:0] w1;
  assign w0 = dbg_weights[DW-1:0];
  assign w1 = dbg_weights[2*DW-1:DW];

  int vectors;
  int miscompares;

  fixed_learning_neuron #(
    .N_INPUTS (N),
    .DATA_W   (DW),
    .FRAC_W   (8),
    .LR_SHIFT (0)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_enable   (in_enable),
    .in_target   (in_target),
    .in_learn    (in_learn),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_value   (out_value),
    .out_err     (out_err),
    .busy        (busy),
    .dbg_state   (dbg_state),
    .dbg_bias    (dbg_bias),
    .dbg_weights (dbg_weights)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic send(input logic [DW-1:0] x0, input logic [DW-1:0] x1,
                      input logic [N-1:0] en, input logic [DW-1:0] tgt,
                      input logic learn);
    in_data   = {x1, x0};
    in_enable = en;
    in_target = tgt;
    in_learn  = learn;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // Scenarios
  task automatic test_reset();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", busy); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    vectors++; if (dbg_weights !== 32'd0) begin miscompares++; $display("FAIL reset_weights got=%h exp=0", dbg_weights); end
    vectors++; if (dbg_bias !== 16'd0) begin miscompares++; $display("FAIL reset_bias got=%h exp=0", dbg_bias); end
  endtask

  task automatic test_inference();
    int lat;
    int cyc;
    send(16'd256, 16'd256, 2'b11, 16'd256, 1'b0);
    wait_out(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL infer_latency got=%0d exp=3", lat); end
    vectors++; if (out_value !== 16'd0) begin miscompares++; $display("FAIL infer_value got=%0d exp=0", out_value); end
    vectors++; if (out_err !== 16'd256) begin miscompares++; $display("FAIL infer_err got=%0d exp=256", out_err); end
    take_out();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL infer_valid_drop got=%b exp=0", out_valid); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL infer_back_idle got=%0d exp=0", dbg_state); end
    wait_idle(cyc);
    vectors++; if (dbg_weights !== 32'd0) begin miscompares++; $display("FAIL infer_weights got=%h exp=0", dbg_weights); end
  endtask

  task automatic test_learning();
    int lat;
    int cyc;
    send(16'd256, 16'd256, 2'b11, 16'd256, 1'b1);
    wait_out(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL learn_latency got=%0d exp=3", lat); end
    vectors++; if (out_err !== 16'd256) begin miscompares++; $display("FAIL learn_err got=%0d exp=256", out_err); end
    take_out();
    vectors++; if (dbg_state !== 2'd3) begin miscompares++; $display("FAIL learn_enter_update got=%0d exp=3", dbg_state); end
    wait_idle(cyc);
    vectors++; if (cyc !== 3) begin miscompares++; $display("FAIL learn_update_len got=%0d exp=3", cyc); end
    vectors++; if (w0 !== 16'd256) begin miscompares++; $display("FAIL learn_w0 got=%0d exp=256", w0); end
    vectors++; if (w1 !== 16'd256) begin miscompares++; $display("FAIL learn_w1 got=%0d exp=256", w1); end
    vectors++; if (dbg_bias !== 16'd256) begin miscompares++; $display("FAIL learn_bias got=%0d exp=256", dbg_bias); end
    // Same sample again: acc = 256 + 256 + 256 = 768 > 0.
    send(16'd256, 16'd256, 2'b11, 16'd256, 1'b1);
    wait_out(lat);
    vectors++; if (out_value !== 16'd256) begin miscompares++; $display("FAIL relearn_value got=%0d exp=256", out_value); end
    vectors++; if (out_err !== 16'd0) begin miscompares++; $display("FAIL relearn_err got=%0d exp=0", out_err); end
    take_out();
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL relearn_skip_update got=%0d exp=0", dbg_state); end
  endtask

  task automatic test_back_to_back();
    int lat;
    int cyc;
    send(16'd256, 16'd256, 2'b11, 16'd0, 1'b0);
    // A second offer while busy must be dropped, not queued.
    in_data  = {16'hFF00, 16'hFF00};
    in_valid = 1'b1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL busy_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_out(lat);
    vectors++; if (out_value !== 16'd256) begin miscompares++; $display("FAIL busy_value got=%0d exp=256", out_value); end
    vectors++; if (out_err !== 16'hFF00) begin miscompares++; $display("FAIL busy_err got=%h exp=ff00", out_err); end
    take_out();
    wait_idle(cyc);
    vectors++; if (cyc !== 0) begin miscompares++; $display("FAIL busy_not_queued got=%0d exp=0", cyc); end
    vectors++; if (w0 !== 16'd256) begin miscompares++; $display("FAIL busy_w0 got=%0d exp=256", w0); end
  endtask

  task automatic test_enable_backpressure();
    int lat;
    int cyc;
    // Only input 0 enabled: acc = 256 + 256 = 512, err = 0 - 256.
    send(16'd256, 16'd256, 2'b01, 16'd0, 1'b1);
    wait_out(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL bp_latency got=%0d exp=3", lat); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_hold cyc=%0d got=%b exp=1", k, out_valid); end
      vectors++; if (out_value !== 16'd256) begin miscompares++; $display("FAIL bp_value_hold cyc=%0d got=%0d exp=256", k, out_value); end
      vectors++; if (out_err !== 16'hFF00) begin miscompares++; $display("FAIL bp_err_hold cyc=%0d got=%h exp=ff00", k, out_err); end
      @(posedge clk); #1;
    end
    take_out();
    wait_idle(cyc);
    vectors++; if (w0 !== 16'd0) begin miscompares++; $display("FAIL bp_w0 got=%0d exp=0", w0); end
    vectors++; if (w1 !== 16'd256) begin miscompares++; $display("FAIL bp_w1 got=%0d exp=256", w1); end
    vectors++; if (dbg_bias !== 16'd0) begin miscompares++; $display("FAIL bp_bias got=%0d exp=0", dbg_bias); end
  endtask

  task automatic test_saturation();
    int lat;
    int cyc;
    pulse_reset();
    vectors++; if (dbg_weights !== 32'd0) begin miscompares++; $display("FAIL sat_clean_weights got=%h exp=0", dbg_weights); end
    // Train w0 to 256*32512/256 = 32512, bias to 256.
    send(16'd32512, 16'd0, 2'b11, 16'd256, 1'b1);
    wait_out(lat);
    take_out();
    wait_idle(cyc);
    vectors++; if (w0 !== 16'd32512) begin miscompares++; $display("FAIL sat_preload_w0 got=%0d exp=32512", w0); end
    // acc = 256 + 127*32767 > 0, err = 32767 - 256 = 32511; w0 then clips.
    send(16'd32767, 16'd0, 2'b11, 16'd32767, 1'b1);
    wait_out(lat);
    vectors++; if (out_value !== 16'd256) begin miscompares++; $display("FAIL sat_value got=%0d exp=256", out_value); end
    vectors++; if (out_err !== 16'd32511) begin miscompares++; $display("FAIL sat_err got=%0d exp=32511", out_err); end
    take_out();
    wait_idle(cyc);
    vectors++; if (w0 !== 16'd32767) begin miscompares++; $display("FAIL sat_w0_clip got=%0d exp=32767", w0); end
    vectors++; if (w1 !== 16'd0) begin miscompares++; $display("FAIL sat_w1 got=%0d exp=0", w1); end
    vectors++; if (dbg_bias !== 16'd32767) begin miscompares++; $display("FAIL sat_bias got=%0d exp=32767", dbg_bias); end
  endtask

  task automatic test_err_saturation();
    int lat;
    int cyc;
    // out_value = 256, target = -32768: full-precision err -33024 clips to -32768.
    send(16'd256, 16'd0, 2'b01, 16'h8000, 1'b0);
    wait_out(lat);
    vectors++; if (out_value !== 16'd256) begin miscompares++; $display("FAIL errsat_value got=%0d exp=256", out_value); end
    vectors++; if (out_err !== 16'h8000) begin miscompares++; $display("FAIL errsat_err got=%h exp=8000", out_err); end
    take_out();
    wait_idle(cyc);
  endtask

  task automatic test_reset_mid_update();
    int lat;
    int cyc;
    // acc = 32767 + 32767 > 0, err = -256 -> UPDATE.
    send(16'd256, 16'd256, 2'b11, 16'd0, 1'b1);
    wait_out(lat);
    take_out();
    vectors++; if (dbg_state !== 2'd3) begin miscompares++; $display("FAIL midupd_enter got=%0d exp=3", dbg_state); end
    @(posedge clk); #1;
    vectors++; if (w0 !== 16'd32511) begin miscompares++; $display("FAIL midupd_partial_w0 got=%0d exp=32511", w0); end
    rst_n = 1'b0;
    #2;
    vectors++; if (dbg_weights !== 32'd0) begin miscompares++; $display("FAIL midupd_weights got=%h exp=0", dbg_weights); end
    vectors++; if (dbg_bias !== 16'd0) begin miscompares++; $display("FAIL midupd_bias got=%h exp=0", dbg_bias); end
    vectors++; if (dbg_state !== 2'd0) begin miscompares++; $display("FAIL midupd_state got=%0d exp=0", dbg_state); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midupd_out_valid got=%b exp=0", out_valid); end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    send(16'd256, 16'd256, 2'b11, 16'd0, 1'b0);
    wait_out(lat);
    vectors++; if (lat !== 3) begin miscompares++; $display("FAIL post_reset_latency got=%0d exp=3", lat); end
    vectors++; if (out_value !== 16'd0) begin miscompares++; $display("FAIL post_reset_value got=%0d exp=0", out_value); end
    vectors++; if (out_err !== 16'd0) begin miscompares++; $display("FAIL post_reset_err got=%0d exp=0", out_err); end
    take_out();
    wait_idle(cyc);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    in_enable   = '0;
    in_target   = '0;
    in_learn    = 1'b0;
    out_ready   = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    test_reset();
    test_inference();
    test_learning();
    test_back_to_back();
    test_enable_backpressure();
    test_saturation();
    test_err_saturation();
    test_reset_mid_update();

    // Final report
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
